// File: rtl/sp_usb_pkg.sv
// Shared types and helpers for the USB FIFO bridge: FSM states, arbitration
// direction constants and the occupancy-counter width function.
package sp_usb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    GAP   = 2'd3
  } state_e;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  // Occupancy counters must represent 0..DEPTH inclusive.
  function automatic int unsigned count_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sp_sync_fifo.sv
// Circular-buffer FIFO with registered storage, fall-through head and
// registered occupancy flags; simultaneous push and pop leave the count unchanged.
module sp_sync_fifo
  import sp_usb_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic [WIDTH-1:0]          data_i,
  input  logic                      pop_i,
  output logic [WIDTH-1:0]          head_c,
  output logic [count_w(DEPTH)-1:0] count_o,
  output logic                      full_o,
  output logic                      empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = count_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  // Full/empty flags track count_q exactly, so they gate on the current count.
  always_comb begin
    push_ok  = push_i && !full_q;
    pop_ok   = pop_i && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_c  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/sp_usb_fifo_bridge.sv
// FT245-style synchronous USB FIFO bridge: TX/RX FIFOs to the stream side,
// fair-arbitrated single-transfer FSM with programmable strobe width and gap.
module sp_usb_fifo_bridge
  import sp_usb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned TX_DEPTH      = 16,
  parameter int unsigned RX_DEPTH      = 16,
  parameter int unsigned STROBE_CYCLES = 1,
  parameter int unsigned GAP_CYCLES    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  inout  wire  [DATA_WIDTH-1:0]        usb_data,
  input  logic                         rxf_n,
  input  logic                         txe_n,
  output logic                         rd_n,
  output logic                         wr_n,
  input  logic [DATA_WIDTH-1:0]        din,
  input  logic                         write,
  output logic                         full,
  output logic [DATA_WIDTH-1:0]        dout,
  input  logic                         read,
  output logic                         avail,
  output logic [count_w(TX_DEPTH)-1:0] tx_count,
  output logic [count_w(RX_DEPTH)-1:0] rx_count
);

  localparam int unsigned CNT_MAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);
  localparam state_e AFTER_XFER = (GAP_CYCLES > 0) ? GAP : IDLE;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  last_dir_q, last_dir_d;
  logic                  tx_pop, rx_push;
  logic                  tx_empty, rx_full, rx_empty;
  logic                  tx_req, rx_req;
  logic [DATA_WIDTH-1:0] tx_head;

  sp_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (write),
    .data_i  (din),
    .pop_i   (tx_pop),
    .head_c  (tx_head),
    .count_o (tx_count),
    .full_o  (full),
    .empty_o (tx_empty)
  );

  sp_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_push),
    .data_i  (usb_data),
    .pop_i   (read),
    .head_c  (dout),
    .count_o (rx_count),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  assign avail  = !rx_empty;
  assign tx_req = !tx_empty && !txe_n;
  assign rx_req = !rx_full && !rxf_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_dir_q <= DIR_READ;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_dir_q <= last_dir_d;
    end
  end

  // Contested grants alternate against last_dir; the counter is loaded on state entry.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_dir_d = last_dir_q;
    tx_pop     = 1'b0;
    rx_push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_req && rx_req) begin
          cnt_d = STROBE_LOAD;
          if (last_dir_q == DIR_READ) begin
            state_d    = WRITE;
            last_dir_d = DIR_WRITE;
          end else begin
            state_d    = READ;
            last_dir_d = DIR_READ;
          end
        end else if (tx_req) begin
          state_d = WRITE;
          cnt_d   = STROBE_LOAD;
        end else if (rx_req) begin
          state_d = READ;
          cnt_d   = STROBE_LOAD;
        end
      end
      WRITE, READ: begin
        if (cnt_q == '0) begin
          tx_pop  = (state_q == WRITE);
          rx_push = (state_q == READ);
          state_d = AFTER_XFER;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_n     = (state_q != READ);
  assign wr_n     = (state_q != WRITE);
  assign usb_data = (state_q == WRITE) ? tx_head : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sp_usb_fifo_bridge.sv
// Directed bench for sp_usb_fifo_bridge: default-parameter instance driven by a
// vector table and hand sequences, plus strobe/gap and mid-transfer reset instances.
module tb_sp_usb_fifo_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance A: default parameters
  logic       rst_a = 1'b1, rxf_n_a = 1'b1, txe_n_a = 1'b1, write_a = 1'b0, read_a = 1'b0, probe_a = 1'b0;
  logic [7:0] din_a = 8'h00;
  wire  [7:0] usb_data_a;
  logic       rd_n_a, wr_n_a, full_a, avail_a;
  logic [7:0] dout_a;
  logic [4:0] tx_count_a, rx_count_a;
  logic [7:0] host_idx_a;

  assign usb_data_a = (!rd_n_a) ? (8'hA0 + host_idx_a) : (probe_a ? 8'h00 : 8'hzz);

  always @(posedge clk) begin
    if (rst_a)        host_idx_a <= 8'd0;
    else if (!rd_n_a) host_idx_a <= host_idx_a + 8'd1;
  end

  sp_usb_fifo_bridge u_a (
    .clk(clk), .rst(rst_a), .usb_data(usb_data_a), .rxf_n(rxf_n_a), .txe_n(txe_n_a),
    .rd_n(rd_n_a), .wr_n(wr_n_a), .din(din_a), .write(write_a), .full(full_a),
    .dout(dout_a), .read(read_a), .avail(avail_a), .tx_count(tx_count_a), .rx_count(rx_count_a)
  );

  // Instance B: 3-cycle strobe, 2-cycle gap
  logic       rst_b = 1'b1, rxf_n_b = 1'b1, txe_n_b = 1'b1, write_b = 1'b0, read_b = 1'b0, probe_b = 1'b0;
  logic [7:0] din_b = 8'h00;
  wire  [7:0] usb_data_b;
  logic       rd_n_b, wr_n_b, full_b, avail_b;
  logic [7:0] dout_b;
  logic [2:0] tx_count_b, rx_count_b;

  assign usb_data_b = (probe_b && wr_n_b) ? 8'h00 : 8'hzz;

  sp_usb_fifo_bridge #(.TX_DEPTH(4), .RX_DEPTH(4), .STROBE_CYCLES(3), .GAP_CYCLES(2)) u_b (
    .clk(clk), .rst(rst_b), .usb_data(usb_data_b), .rxf_n(rxf_n_b), .txe_n(txe_n_b),
    .rd_n(rd_n_b), .wr_n(wr_n_b), .din(din_b), .write(write_b), .full(full_b),
    .dout(dout_b), .read(read_b), .avail(avail_b), .tx_count(tx_count_b), .rx_count(rx_count_b)
  );

  // Instance C: 4-cycle strobe, no gap
  logic       rst_c = 1'b1, rxf_n_c = 1'b1, txe_n_c = 1'b1, write_c = 1'b0, read_c = 1'b0;
  logic [7:0] din_c = 8'h00;
  wire  [7:0] usb_data_c;
  logic       rd_n_c, wr_n_c, full_c, avail_c;
  logic [7:0] dout_c;
  logic [2:0] tx_count_c, rx_count_c;

  assign usb_data_c = (!rd_n_c) ? 8'hC3 : 8'hzz;

  sp_usb_fifo_bridge #(.TX_DEPTH(4), .RX_DEPTH(4), .STROBE_CYCLES(4), .GAP_CYCLES(0)) u_c (
    .clk(clk), .rst(rst_c), .usb_data(usb_data_c), .rxf_n(rxf_n_c), .txe_n(txe_n_c),
    .rd_n(rd_n_c), .wr_n(wr_n_c), .din(din_c), .write(write_c), .full(full_c),
    .dout(dout_c), .read(read_c), .avail(avail_c), .tx_count(tx_count_c), .rx_count(rx_count_c)
  );

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] din;
    logic       txe_n;
    logic       rxf_n;
    logic       e_rd_n;
    logic       e_wr_n;
    logic       e_full;
    logic       e_avail;
    logic [4:0] e_txc;
    logic [4:0] e_rxc;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  int   pulses, lows, highrun, lowrun, rds, n, wi, widx;
  logic prev, full_chk;
  bit [7:0] grants;
  bit [7:0] exp_grants;

  initial begin
    // Reset rows, then 16 pushes into an idle link, then an ignored 17th write
    for (int i = 0; i < 3; i++)
      vecs[i] = '{rst:1'b1, wr:1'b0, din:8'h00, txe_n:1'b0, rxf_n:1'b0,
                  e_rd_n:1'b1, e_wr_n:1'b1, e_full:1'b0, e_avail:1'b0, e_txc:5'd0, e_rxc:5'd0};
    for (int i = 0; i < 16; i++)
      vecs[3+i] = '{rst:1'b0, wr:1'b1, din:8'(8'h11 + i), txe_n:1'b1, rxf_n:1'b1,
                    e_rd_n:1'b1, e_wr_n:1'b1, e_full:(i == 15), e_avail:1'b0,
                    e_txc:5'(i + 1), e_rxc:5'd0};
    vecs[19] = '{rst:1'b0, wr:1'b1, din:8'h99, txe_n:1'b1, rxf_n:1'b1,
                 e_rd_n:1'b1, e_wr_n:1'b1, e_full:1'b1, e_avail:1'b0, e_txc:5'd16, e_rxc:5'd0};
    vecs[20] = '{rst:1'b0, wr:1'b0, din:8'h00, txe_n:1'b1, rxf_n:1'b1,
                 e_rd_n:1'b1, e_wr_n:1'b1, e_full:1'b1, e_avail:1'b0, e_txc:5'd16, e_rxc:5'd0};

    probe_a = 1'b1;
    for (int i = 0; i < NV; i++) begin
      rst_a = vecs[i].rst; write_a = vecs[i].wr; din_a = vecs[i].din;
      txe_n_a = vecs[i].txe_n; rxf_n_a = vecs[i].rxf_n;
      tick();
      check($sformatf("v%0d rd_n", i), rd_n_a, vecs[i].e_rd_n);
      check($sformatf("v%0d wr_n", i), wr_n_a, vecs[i].e_wr_n);
      check($sformatf("v%0d full", i), full_a, vecs[i].e_full);
      check($sformatf("v%0d avail", i), avail_a, vecs[i].e_avail);
      check($sformatf("v%0d tx_count", i), tx_count_a, vecs[i].e_txc);
      check($sformatf("v%0d rx_count", i), rx_count_a, vecs[i].e_rxc);
      check($sformatf("v%0d bus_released", i), usb_data_a, 8'h00);
    end
    probe_a = 1'b0;
    write_a = 1'b0;

    // TX drain: 16 single-cycle wr_n pulses separated by one IDLE cycle
    txe_n_a = 1'b0;
    pulses = 0; lows = 0; highrun = 0; prev = 1'b1; full_chk = 1'b0;
    for (int c = 0; c < 80 && pulses < 16; c++) begin
      tick();
      if (!wr_n_a) begin
        lows++;
        if (prev) begin
          check($sformatf("tx_bus%0d", pulses), usb_data_a, 8'h11 + pulses);
          if (pulses > 0) check("tx_idle_gap", highrun, 1);
          pulses++;
        end
        highrun = 0;
      end else begin
        highrun++;
        if (pulses == 1 && !full_chk) begin
          full_chk = 1'b1;
          check("tx_full_clear", full_a, 0);
          check("tx_count_15", tx_count_a, 15);
        end
      end
      prev = wr_n_a;
    end
    check("tx_pulses", pulses, 16);
    for (int c = 0; c < 6; c++) begin
      tick();
      if (!wr_n_a) lows++;
    end
    check("tx_low_cycles", lows, 16);
    check("tx_drained", tx_count_a, 0);
    check("tx_full_end", full_a, 0);

    // RX fill until full, then one pop allows exactly one more read
    txe_n_a = 1'b1; rxf_n_a = 1'b0; rds = 0;
    for (int c = 0; c < 100 && rx_count_a != 5'd16; c++) begin
      tick();
      if (!rd_n_a) rds++;
    end
    check("rx_count_16", rx_count_a, 16);
    check("rx_reads_16", rds, 16);
    check("rx_avail", avail_a, 1);
    check("rx_head_a0", dout_a, 8'hA0);
    rds = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (!rd_n_a) rds++;
    end
    check("rx_hold_when_full", rds, 0);
    read_a = 1'b1;
    tick();
    read_a = 1'b0;
    rds = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (!rd_n_a) rds++;
    end
    check("rx_refill_one", rds, 1);
    check("rx_count_refill", rx_count_a, 16);
    rxf_n_a = 1'b1; read_a = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("rx_dout%0d", k), dout_a, 8'hA1 + k);
      tick();
    end
    read_a = 1'b0;
    check("rx_avail_drop", avail_a, 0);
    check("rx_count_0", rx_count_a, 0);

    // Contention: 3 TX words with the host always ready both ways
    write_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din_a = 8'(8'h31 + k);
      tick();
    end
    write_a = 1'b0;
    check("cont_tx_count", tx_count_a, 3);
    rxf_n_a = 1'b0; txe_n_a = 1'b0;
    n = 0; wi = 0; grants = '0; exp_grants = 8'b0001_0101;
    for (int c = 0; c < 40 && n < 8; c++) begin
      tick();
      if (!wr_n_a) begin
        grants[n] = 1'b1;
        check($sformatf("cont_bus%0d", wi), usb_data_a, 8'h31 + wi);
        wi++; n++;
      end else if (!rd_n_a) begin
        grants[n] = 1'b0;
        n++;
      end
    end
    check("cont_grants", n, 8);
    for (int i = 0; i < 8; i++) check($sformatf("cont_grant%0d", i), grants[i], exp_grants[i]);
    rxf_n_a = 1'b1; txe_n_a = 1'b1;

    // Instance B: strobe width, gap and bus-enable window
    rst_b = 1'b0;
    tick(); tick();
    write_b = 1'b1; din_b = 8'h5C;
    tick();
    din_b = 8'h5D;
    tick();
    write_b = 1'b0;
    check("b_tx_count", tx_count_b, 2);
    probe_b = 1'b1; txe_n_b = 1'b0;
    prev = 1'b1; lowrun = 0; highrun = 0; pulses = 0; widx = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (!wr_n_b) begin
        if (prev) begin
          if (pulses > 0) check("b_gap_ge3", (highrun >= 3), 1);
          widx = pulses;
          pulses++;
        end
        check($sformatf("b_bus%0d", widx), usb_data_b, (widx == 0) ? 8'h5C : 8'h5D);
        lowrun++;
        highrun = 0;
      end else begin
        if (!prev) check("b_low_len", lowrun, 3);
        lowrun = 0;
        highrun++;
        if (tx_count_b != 3'd0) check("b_bus_released", usb_data_b, 8'h00);
      end
      prev = wr_n_b;
    end
    check("b_pulses", pulses, 2);
    check("b_tx_empty", tx_count_b, 0);
    probe_b = 1'b0; txe_n_b = 1'b1;

    // Instance C: full 4-cycle read, then reset in the 2nd low cycle of the next
    rst_c = 1'b0;
    tick(); tick();
    rxf_n_c = 1'b0;
    for (int c = 0; c < 10 && rd_n_c; c++) tick();
    check("c_rd_start", rd_n_c, 0);
    rxf_n_c = 1'b1;
    lowrun = 1;
    for (int c = 0; c < 10 && !rd_n_c; c++) begin
      tick();
      if (!rd_n_c) lowrun++;
    end
    check("c_low_len", lowrun, 4);
    check("c_rx_count_1", rx_count_c, 1);
    check("c_avail", avail_c, 1);
    check("c_dout", dout_c, 8'hC3);
    rxf_n_c = 1'b0;
    for (int c = 0; c < 10 && rd_n_c; c++) tick();
    check("c_rd_start2", rd_n_c, 0);
    tick();
    check("c_rd_2nd_low", rd_n_c, 0);
    rst_c = 1'b1;
    tick();
    check("c_rst_rd_n", rd_n_c, 1);
    check("c_rst_wr_n", wr_n_c, 1);
    check("c_rst_rx_count", rx_count_c, 0);
    check("c_rst_avail", avail_c, 0);
    rxf_n_c = 1'b1;
    tick();
    rst_c = 1'b0;
    tick(); tick();
    check("c_post_rx_count", rx_count_c, 0);
    check("c_post_rd_n", rd_n_c, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sp_usb_fifo_bridge.md
# sp_usb_fifo_bridge

Parametrised bridge between the FT245-style synchronous USB FIFO pins (shared tri-state data bus, rxf_n/txe_n flags, rd_n/wr_n strobes) and the on-chip stream interface. It replaces single-byte staging with independent TX and RX FIFOs, so host traffic can burst in both directions. Strobe width and inter-transfer gap are programmable, and contested cycles are arbitrated fairly. It sits between the board USB pins and the kernel-side stream adapters.

## Interface
- DATA_WIDTH, 8: USB bus and stream word width.
- TX_DEPTH, 16: TX FIFO entries, power of two, ≥2.
- RX_DEPTH, 16: RX FIFO entries, power of two, ≥2.
- STROBE_CYCLES, 1: cycles rd_n/wr_n held low per transfer, ≥1.
- GAP_CYCLES, 0: idle cycles forced after each transfer, ≥0.

- clk  in  1  clock; reset rst, synchronous, active-high.
- rst  in  1  synchronous active-high reset.
- usb_data  inout  DATA_WIDTH  USB data bus; driven only in WRITE, else z.
- rxf_n  in  1  low: host has a word for us.
- txe_n  in  1  low: host can accept a word.
- rd_n  out  1  read strobe, active low.
- wr_n  out  1  write strobe, active low.
- din  in  DATA_WIDTH  TX word.
- write  in  1  push din when !full.
- full  out  1  TX FIFO count == TX_DEPTH.
- dout  out  DATA_WIDTH  RX FIFO head (first-word fall-through).
- read  in  1  pop RX head when avail.
- avail  out  1  RX FIFO nonempty.
- tx_count  out  $clog2(TX_DEPTH+1)  TX occupancy.
- rx_count  out  $clog2(RX_DEPTH+1)  RX occupancy.

## Operation
- FIFOs are circular buffers with wrapping read and write pointers. Push and pop may occur in the same cycle; the count is unchanged in that case.
- write while full is ignored; full is judged on the current count, even if a pop happens in the same cycle. read while !avail is ignored.
- FSM states: IDLE, WRITE, READ, GAP.
- IDLE:
  - tx_req = tx_count≠0 & !txe_n.
  - rx_req = rx_count<RX_DEPTH & !rxf_n.
  - Only tx_req → WRITE. Only rx_req → READ.
  - Both → opposite direction of last_dir, then update last_dir.
  - Neither → stay in IDLE.
- WRITE: usb_data = TX head, wr_n low for STROBE_CYCLES. TX pops on the last strobe cycle. Next state is GAP if GAP_CYCLES>0, else IDLE.
- READ: rd_n low for STROBE_CYCLES. usb_data is sampled and pushed to RX on the last strobe cycle. Next state as for WRITE.
- GAP: strobes high and bus z for GAP_CYCLES, then IDLE.
- A single strobe/gap counter is loaded on state entry.
- rd_n, wr_n and the bus enable are decoded from state only.
- rxf_n/txe_n changes during a strobe do not abort the transfer.
- Only one USB transfer is in flight, so RX space checked in IDLE is guaranteed at push time.

## Timing
- Reset values: state IDLE, rd_n=1, wr_n=1, usb_data z, full=0, avail=0, tx_count=0, rx_count=0, last_dir=READ (first contested grant goes to WRITE). dout is don't-care until avail.
- rst asserted mid-transfer: strobes return high and the bus releases the cycle after rst is sampled. FIFO contents are discarded.
- Transfer period is 1+STROBE_CYCLES+GAP_CYCLES cycles (IDLE decision, strobes, gap).
- TX latency: write at cycle t into an empty FIFO with txe_n low gives IDLE decision at t+1 and wr_n low at t+2 … t+1+STROBE_CYCLES.
- RX latency: with RX empty, avail and dout are valid the cycle after the last rd_n-low cycle.
- full rises the cycle after the push that fills the FIFO; avail drops the cycle after the pop that empties it.
- Throughput with both directions saturated: strictly alternating WRITE/READ.

## Structure
- Package sp_usb_pkg holds:
  - the state enum (IDLE, WRITE, READ, GAP);
  - the direction constants DIR_READ/DIR_WRITE;
  - a count-width function wrapping $clog2(DEPTH+1).
- Sub-module sp_sync_fifo (WIDTH, DEPTH) provides push/pop, head, count and full/empty, with registered storage and fall-through head. It is instantiated twice (TX, RX).
- The top level contains only the FSM, the strobe/gap counter, last_dir and the tri-state bus.

## Test plan
- **Reset, idle bus.** rst high 3 cycles with rxf_n=0, txe_n=0 → rd_n=wr_n=1, bus z, full=0, avail=0, both counts 0.
- **TX burst, default parameters.** Push 0x11..0x20 (16 words) back-to-back with txe_n=1 → full=1 after the 16th, 17th write ignored. Then txe_n=0 → 16 wr_n pulses, each 1 cycle low with a 1-cycle IDLE between. Bus shows 0x11..0x20 in order; full clears after the first pop.
- **RX fill.** rxf_n=0 constantly, host supplies 0xA0+i → after 16 reads rx_count=16 and rd_n stays high. One read pop → exactly one more rd_n pulse. dout sequence 0xA0, 0xA1, … with no loss.
- **Contention.** TX holds 3 words, rxf_n=0, txe_n=0 → grants go WRITE, READ, WRITE, READ, WRITE, then READ only.
- **Strobe/gap parameters.** STROBE_CYCLES=3, GAP_CYCLES=2 → wr_n low exactly 3 cycles, bus driven only in those cycles, next strobe no earlier than 3 cycles after release.
- **Reset mid-transfer.** STROBE_CYCLES=4, assert rst in the 2nd low cycle of rd_n → rd_n=1 next cycle, rx_count=0, avail=0, nothing pushed.
